// File: rtl/add8u_err_pkg.sv
// Shared widths, FSM state type and helpers for the add8u error monitor.
// The ADD8U_ERR_MSE_EN macro (used by importers) enables squared-error accumulation.
package add8u_err_pkg;

    localparam int W_OP   = 8;
    localparam int W_SUM  = 9;
    localparam int W_DIFF = 10;
    localparam int W_SQ   = 18;
    localparam int W_CNT  = 17;
    localparam int W_SAE  = 26;
    localparam int W_SSE  = 35;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // |d| of a 10-bit signed difference; the magnitude never exceeds 511.
    function automatic logic [W_SUM-1:0] abs_diff(input logic signed [W_DIFF-1:0] d);
        logic signed [W_DIFF-1:0] neg;
        neg = -d;
        return d[W_DIFF-1] ? W_SUM'(neg) : W_SUM'(d);
    endfunction

endpackage

// File: rtl/add8u_err_calc.sv
// Combinational stage-1 error calculation: exact sum, absolute error and,
// when ADD8U_ERR_MSE_EN is defined, the squared error.
module add8u_err_calc
    import add8u_err_pkg::*;
(
    input  logic [W_OP-1:0]  a,
    input  logic [W_OP-1:0]  b,
    input  logic [W_SUM-1:0] o,
    output logic [W_SUM-1:0] err
`ifdef ADD8U_ERR_MSE_EN
    ,
    output logic [W_SQ-1:0]  sq
`endif
);

    logic [W_SUM-1:0]         exact;
    logic signed [W_DIFF-1:0] diff;

    always_comb begin
        exact = W_SUM'(a) + W_SUM'(b);
        // Zero-extend both sides so the subtraction cannot wrap.
        diff  = signed'({1'b0, o}) - signed'({1'b0, exact});
        err   = abs_diff(diff);
    end

`ifdef ADD8U_ERR_MSE_EN
    assign sq = W_SQ'(err) * W_SQ'(err);
`endif

endmodule

// File: rtl/add8u_err_monitor.sv
// Streaming error-metric accumulator for approximate 8-bit adders.
// Build with ADD8U_ERR_MSE_EN defined to include the squared-error (sse) path.
module add8u_err_monitor
    import add8u_err_pkg::*;
#(
    parameter int NSAMP = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_OP-1:0]  in_a,
    input  logic [W_OP-1:0]  in_b,
    input  logic [W_SUM-1:0] in_o,
    output logic             busy,
    output logic             done,
    output logic [W_CNT-1:0] smp_cnt,
    output logic [W_CNT-1:0] err_cnt,
    output logic [W_SAE-1:0] sum_abs_err,
    output logic [W_SUM-1:0] max_err,
    output logic [W_OP-1:0]  max_a,
    output logic [W_OP-1:0]  max_b,
    output logic [W_SSE-1:0] sse
);

    localparam logic [W_CNT-1:0] NSAMP_C = W_CNT'(NSAMP);

    state_t           state_q, state_d;
    logic [W_CNT-1:0] acc_cnt_q, acc_cnt_d;
    logic             drain_cnt_q, drain_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s1_vld_q, s1_vld_d;
    logic [W_SUM-1:0] s1_err_q, s1_err_d;
    logic [W_OP-1:0]  s1_a_q, s1_a_d;
    logic [W_OP-1:0]  s1_b_q, s1_b_d;

    logic [W_CNT-1:0] smp_cnt_q, smp_cnt_d;
    logic [W_CNT-1:0] err_cnt_q, err_cnt_d;
    logic [W_SAE-1:0] sae_q, sae_d;
    logic [W_SUM-1:0] max_err_q, max_err_d;
    logic [W_OP-1:0]  max_a_q, max_a_d;
    logic [W_OP-1:0]  max_b_q, max_b_d;

    logic             accept;
    logic [W_SUM-1:0] calc_err;

`ifdef ADD8U_ERR_MSE_EN
    logic [W_SQ-1:0]  calc_sq;
    logic [W_SQ-1:0]  s1_sq_q, s1_sq_d;
    logic [W_SSE-1:0] sse_q, sse_d;
`endif

    add8u_err_calc u_calc (
        .a   (in_a),
        .b   (in_b),
        .o   (in_o),
        .err (calc_err)
`ifdef ADD8U_ERR_MSE_EN
        ,
        .sq  (calc_sq)
`endif
    );

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        drain_cnt_d = drain_cnt_q;

        // Stage 1: capture the error of the accepted sample.
        s1_vld_d = accept;
        s1_err_d = s1_err_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        if (accept) begin
            s1_err_d = calc_err;
            s1_a_d   = in_a;
            s1_b_d   = in_b;
        end

        // Stage 2: fold the registered sample into the run totals.
        smp_cnt_d = smp_cnt_q;
        err_cnt_d = err_cnt_q;
        sae_d     = sae_q;
        max_err_d = max_err_q;
        max_a_d   = max_a_q;
        max_b_d   = max_b_q;
        if (s1_vld_q) begin
            smp_cnt_d = smp_cnt_q + W_CNT'(1);
            err_cnt_d = err_cnt_q + W_CNT'(s1_err_q != '0);
            sae_d     = sae_q + W_SAE'(s1_err_q);
            // Strictly greater: ties keep the earliest worst-case operands.
            if (s1_err_q > max_err_q) begin
                max_err_d = s1_err_q;
                max_a_d   = s1_a_q;
                max_b_d   = s1_b_q;
            end
        end

`ifdef ADD8U_ERR_MSE_EN
        s1_sq_d = s1_sq_q;
        if (accept) begin
            s1_sq_d = calc_sq;
        end
        sse_d = sse_q;
        if (s1_vld_q) begin
            sse_d = sse_q + W_SSE'(s1_sq_q);
        end
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    acc_cnt_d   = '0;
                    drain_cnt_d = 1'b0;
                    s1_vld_d    = 1'b0;
                    smp_cnt_d   = '0;
                    err_cnt_d   = '0;
                    sae_d       = '0;
                    max_err_d   = '0;
                    max_a_d     = '0;
                    max_b_d     = '0;
`ifdef ADD8U_ERR_MSE_EN
                    sse_d       = '0;
`endif
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + W_CNT'(1);
                    if (acc_cnt_d == NSAMP_C) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Two drain cycles let the final sample clear both stages.
                drain_cnt_d = 1'b1;
                if (drain_cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RUN) && (acc_cnt_d < NSAMP_C);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_err_q    <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            smp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            sae_q       <= '0;
            max_err_q   <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_vld_q    <= s1_vld_d;
            s1_err_q    <= s1_err_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            smp_cnt_q   <= smp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sae_q       <= sae_d;
            max_err_q   <= max_err_d;
            max_a_q     <= max_a_d;
            max_b_q     <= max_b_d;
        end
    end

`ifdef ADD8U_ERR_MSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sq_q <= '0;
            sse_q   <= '0;
        end else begin
            s1_sq_q <= s1_sq_d;
            sse_q   <= sse_d;
        end
    end

    assign sse = sse_q;
`else
    assign sse = '0;
`endif

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign smp_cnt     = smp_cnt_q;
    assign err_cnt     = err_cnt_q;
    assign sum_abs_err = sae_q;
    assign max_err     = max_err_q;
    assign max_a       = max_a_q;
    assign max_b       = max_b_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed self-checking bench for add8u_err_monitor (NSAMP=4 runs).
module tb_add8u_err_monitor;

`ifdef ADD8U_ERR_MSE_EN
    localparam bit MSE = 1'b1;
`else
    localparam bit MSE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [8:0]  in_o = '0;
    logic        busy;
    logic        done;
    logic [16:0] smp_cnt;
    logic [16:0] err_cnt;
    logic [25:0] sum_abs_err;
    logic [8:0]  max_err;
    logic [7:0]  max_a;
    logic [7:0]  max_b;
    logic [34:0] sse;

    int checks = 0;
    int errors = 0;

    add8u_err_monitor #(.NSAMP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_o        (in_o),
        .busy        (busy),
        .done        (done),
        .smp_cnt     (smp_cnt),
        .err_cnt     (err_cnt),
        .sum_abs_err (sum_abs_err),
        .max_err     (max_err),
        .max_a       (max_a),
        .max_b       (max_b),
        .sse         (sse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a sample and hold it until the handshake edge has passed.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int n;
        in_a = a;
        in_b = b;
        in_o = o;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", in_ready, 1);
        tick();
    endtask

    // Called just after the final accept edge: done must rise two edges later.
    task automatic finish_run(input string tag);
        in_valid = 1'b0;
        chk({tag, "_ready_after_last"}, in_ready, 0);
        tick();
        chk({tag, "_done_k1"}, done, 0);
        chk({tag, "_busy_k1"}, busy, 1);
        tick();
        chk({tag, "_done_k2"}, done, 1);
        chk({tag, "_busy_k2"}, busy, 0);
    endtask

    task automatic chk_results(input string tag, input int e_smp, input int e_cnt, input int e_sae,
                               input int e_max, input int e_a, input int e_b, input longint e_sse);
        chk({tag, "_smp_cnt"}, smp_cnt, e_smp);
        chk({tag, "_err_cnt"}, err_cnt, e_cnt);
        chk({tag, "_sum_abs_err"}, sum_abs_err, e_sae);
        chk({tag, "_max_err"}, max_err, e_max);
        chk({tag, "_max_a"}, max_a, e_a);
        chk({tag, "_max_b"}, max_b, e_b);
        chk({tag, "_sse"}, sse, MSE ? e_sse : 0);
    endtask

    initial begin
        int gap;
        // Reset state; samples offered in IDLE must be ignored.
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd9;
        in_b = 8'd9;
        in_o = 9'd0;
        tick();
        tick();
        in_valid = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        chk_results("rst", 0, 0, 0, 0, 0, 0, 0);
        $display("txn reset: idle outputs checked");

        // Run 1: mixed errors, continuous valid.
        pulse_start();
        chk("r1_busy", busy, 1);
        chk("r1_ready", in_ready, 1);
        send(8'd3, 8'd5, 9'd8);
        send(8'd3, 8'd5, 9'd10);
        send(8'd255, 8'd255, 9'd510);
        send(8'd0, 8'd0, 9'd7);
        finish_run("r1");
        chk_results("r1", 4, 2, 9, 7, 0, 0, 53);
        tick();
        tick();
        tick();
        chk("r1_hold_done", done, 1);
        chk("r1_hold_sae", sum_abs_err, 9);
        $display("txn run1: sae=%0d cnt=%0d max=%0d sse=%0d", sum_abs_err, err_cnt, max_err, sse);

        // Run 2: ties on max keep the earliest operands; start in RUN ignored.
        pulse_start();
        chk("r2_cleared_smp", smp_cnt, 0);
        chk("r2_cleared_sae", sum_abs_err, 0);
        chk("r2_done_low", done, 0);
        send(8'd1, 8'd1, 9'd5);
        send(8'd2, 8'd2, 9'd7);
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("r2_start_ignored_smp", smp_cnt, 2);
        chk("r2_start_ignored_ready", in_ready, 1);
        send(8'd9, 8'd9, 9'd18);
        send(8'd4, 8'd4, 9'd5);
        finish_run("r2");
        chk_results("r2", 4, 3, 9, 3, 1, 1, 27);
        $display("txn run2: max=%0d a=%0d b=%0d", max_err, max_a, max_b);

        // Run 3: underestimates, carry-out sum and the 511 ceiling.
        pulse_start();
        send(8'd200, 8'd100, 9'd0);
        send(8'd255, 8'd255, 9'd0);
        send(8'd0, 8'd0, 9'd511);
        send(8'd0, 8'd0, 9'd0);
        finish_run("r3");
        chk_results("r3", 4, 3, 1321, 511, 0, 0, 611221);
        $display("txn run3: sae=%0d max=%0d sse=%0d", sum_abs_err, max_err, sse);

        // Run 4: random valid gaps, then extra samples offered after the last.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            case (i)
                0: send(8'd10, 8'd20, 9'd31);
                1: send(8'd7, 8'd8, 9'd15);
                2: send(8'd100, 8'd100, 9'd199);
                default: send(8'd50, 8'd60, 9'd100);
            endcase
        end
        chk("r4_ready_after_last", in_ready, 0);
        in_a = 8'd0;
        in_b = 8'd0;
        in_o = 9'd300;
        repeat (5) tick();
        in_valid = 1'b0;
        chk("r4_done", done, 1);
        chk_results("r4", 4, 3, 12, 10, 50, 60, 102);
        $display("txn run4: smp=%0d sae=%0d max=%0d", smp_cnt, sum_abs_err, max_err);

        // Run 5: asynchronous reset mid-run discards everything.
        pulse_start();
        send(8'd1, 8'd1, 9'd0);
        send(8'd2, 8'd2, 9'd0);
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("r5_rst_busy", busy, 0);
        chk("r5_rst_ready", in_ready, 0);
        chk("r5_rst_sae", sum_abs_err, 0);
        chk("r5_rst_smp", smp_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("r5_idle_ready", in_ready, 0);
        pulse_start();
        send(8'd11, 8'd22, 9'd33);
        send(8'd128, 8'd128, 9'd256);
        send(8'd255, 8'd1, 9'd256);
        send(8'd0, 8'd255, 9'd255);
        finish_run("r5");
        chk_results("r5", 4, 0, 0, 0, 0, 0, 0);
        $display("txn run5: clean run smp=%0d err_cnt=%0d", smp_cnt, err_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
